// File: rtl/core_clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_clk_pkg: shared types and defaults for core clock/reset blocks.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package core_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_NUM_OUTPUTS        = 3;
  localparam int unsigned DEF_STAGE_CYCLES       = 16;
  localparam int unsigned DEF_LOSS_CNT_W         = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_bit: STAGES-deep single-bit synchronizer, async reset to 0.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_reset_sequencer: staged core resets released after stable PLL lock,    |
// | with a saturating lock-loss counter. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
module pll_reset_sequencer
  import core_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned NUM_OUTPUTS        = DEF_NUM_OUTPUTS,
  parameter int unsigned STAGE_CYCLES       = DEF_STAGE_CYCLES,
  parameter int unsigned LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   clear_loss,
  output logic [NUM_OUTPUTS-1:0] rst_out,
  output logic                   ready,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count
);

  localparam int unsigned CNT_W = $clog2(max_u(LOCK_STABLE_CYCLES, STAGE_CYCLES) + 1);
  localparam int unsigned IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  localparam logic [CNT_W-1:0] c_lock_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stage_last = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_OUTPUTS - 1);

  logic                   locked_s;
  logic                   loss_evt;
  seq_state_e             state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [IDX_W-1:0]       idx_q,     idx_d;
  logic [NUM_OUTPUTS-1:0] rst_out_q, rst_out_d;
  logic                   ready_q,   ready_d;
  logic [LOSS_CNT_W-1:0]  loss_q,    loss_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    loss_d    = loss_q;
    loss_evt  = 1'b0;

    case (state_q)
      // The cycle that first sees lock counts as the first stable cycle.
      WAIT_LOCK: begin
        cnt_d = '0;
        idx_d = '0;
        if (locked_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_d = RELEASE;
          end else begin
            state_d = STABLE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == c_lock_last) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          loss_evt = 1'b1;
        end else if (cnt_q == c_stage_last) begin
          cnt_d     = '0;
          rst_out_d = rst_out_q & ~(NUM_OUTPUTS'(1) << idx_q);
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == c_idx_last) begin
            ready_d = 1'b1;
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          loss_evt = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (loss_evt) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end

    // A loss coinciding with a clear leaves exactly that one loss on record.
    if (loss_evt) begin
      if (clear_loss) begin
        loss_d = LOSS_CNT_W'(1);
      end else if (loss_q != '1) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end else if (clear_loss) begin
      loss_d = '0;
    end
  end

  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pll_reset_sequencer: randomized and directed bench with a run-length    |
// | reference model of lock, staged release and loss counting. Revision: 1.0   |
// +----------------------------------------------------------------------------+
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int L    = 8;
  localparam int S    = 4;
  localparam int NUM  = 3;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           pll_locked = 1'b0;
  logic           clear_loss = 1'b0;
  logic [NUM-1:0] rst_out,  rst_out_sat;
  logic           ready,    ready_sat;
  logic [7:0]     cnt8;
  logic [1:0]     cnt2;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(L), .NUM_OUTPUTS(NUM),
    .STAGE_CYCLES(S), .LOSS_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .clear_loss(clear_loss),
    .rst_out(rst_out), .ready(ready), .lock_loss_count(cnt8)
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(L), .NUM_OUTPUTS(NUM),
    .STAGE_CYCLES(S), .LOSS_CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .clear_loss(clear_loss),
    .rst_out(rst_out_sat), .ready(ready_sat), .lock_loss_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: m_n is the run length of consecutive cycles the FSM has seen
  // lock; a bit releases once the run covers the stable window plus its stage.
  logic [SYNC-1:0] m_hist = '0;
  int              m_n    = 0;
  int              m_c8   = 0;
  int              m_c2   = 0;

  function automatic int next_cnt(input int c, input bit loss, input bit clr, input int maxv);
    if (loss) return clr ? 1 : ((c < maxv) ? c + 1 : c);
    if (clr)  return 0;
    return c;
  endfunction

  function automatic logic [NUM-1:0] exp_rst(input int n);
    logic [NUM-1:0] r;
    for (int k = 0; k < NUM; k++) r[k] = !(n >= L + (k + 1) * S);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist <= '0;
      m_n    <= 0;
      m_c8   <= 0;
      m_c2   <= 0;
    end else begin
      m_hist <= {m_hist[SYNC-2:0], pll_locked};
      m_n    <= m_hist[SYNC-1] ? ((m_n < 100000) ? m_n + 1 : m_n) : 0;
      m_c8   <= next_cnt(m_c8, !m_hist[SYNC-1] && (m_n >= L), clear_loss, 255);
      m_c2   <= next_cnt(m_c2, !m_hist[SYNC-1] && (m_n >= L), clear_loss, 3);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("mon_rst_out", rst_out,     exp_rst(m_n));
      check_val("mon_ready",   ready,       (m_n >= L + NUM * S));
      check_val("mon_cnt8",    cnt8,        m_c8);
      check_val("mon_cnt2",    cnt2,        m_c2);
      check_val("mon_rst_sat", rst_out_sat, exp_rst(m_n));
    end
  end

  // Call right after the first cycle of pll_locked=1 is set up; edge 1 is the next edge.
  task automatic measure_release(input string tag);
    int fall[NUM];
    int rdy_e;
    for (int k = 0; k < NUM; k++) fall[k] = 0;
    rdy_e = 0;
    for (int e = 1; e <= 80 && rdy_e == 0; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM; k++)
        if (fall[k] == 0 && !rst_out[k]) fall[k] = e;
      if (ready) rdy_e = e;
    end
    for (int k = 0; k < NUM; k++)
      check_val($sformatf("%s_fall%0d", tag, k), fall[k], SYNC + L + (k + 1) * S);
    check_val({tag, "_ready_edge"}, rdy_e, SYNC + L + NUM * S);
  endtask

  task automatic measure_loss(input string tag);
    int hit;
    hit = 0;
    for (int e = 1; e <= 10 && hit == 0; e++) begin
      @(posedge clk);
      #1;
      if (rst_out == '1 && !ready) hit = e;
    end
    check_val({tag, "_loss_edge"}, hit, SYNC + 1);
  endtask

  task automatic wait_bit0_low(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      @(negedge clk);
      if (!rst_out[0]) ok = 1;
    end
    check_val({tag, "_bit0_seen"}, ok, 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_loss = 1'b1;
    @(negedge clk); clear_loss = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_rst_out", rst_out, 3'b111);
    check_val("reset_ready",   ready,   0);
    check_val("reset_cnt",     cnt8,    0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Clean lock
    pll_locked = 1'b1;
    measure_release("clean");
    check_val("clean_cnt", cnt8, 0);

    // Loss in RUN, then relock
    @(negedge clk); pll_locked = 1'b0;
    measure_loss("run");
    check_val("run_cnt", cnt8, 1);
    @(negedge clk); @(negedge clk);
    pll_locked = 1'b1;
    measure_release("relock");

    // Pre-release glitch
    @(negedge clk); pll_locked = 1'b0;
    repeat (6) @(negedge clk);
    pulse_clear();
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    measure_release("glitch");
    check_val("glitch_cnt", cnt8, 0);

    // Loss mid-RELEASE
    @(negedge clk); pll_locked = 1'b0;
    repeat (6) @(negedge clk);
    pulse_clear();
    pll_locked = 1'b1;
    wait_bit0_low("mid");
    pll_locked = 1'b0;
    measure_loss("mid");
    check_val("mid_cnt", cnt8, 1);
    repeat (4) @(negedge clk);

    // Randomized lock/unlock segments with sporadic clears
    for (int i = 0; i < 30; i++) begin
      pll_locked = 1'b1;
      repeat ($urandom_range(1, 45)) begin
        @(negedge clk);
        clear_loss = ($urandom_range(0, 15) == 0);
      end
      pll_locked = 1'b0;
      repeat ($urandom_range(1, 6)) begin
        @(negedge clk);
        clear_loss = ($urandom_range(0, 15) == 0);
      end
    end
    clear_loss = 1'b0;
    repeat (4) @(negedge clk);

    // Saturation and clear
    pulse_clear();
    repeat (5) begin
      pll_locked = 1'b1;
      repeat (14) @(negedge clk);
      pll_locked = 1'b0;
      repeat (5) @(negedge clk);
    end
    check_val("sat_cnt2", cnt2, 3);
    check_val("sat_cnt8", cnt8, 5);
    pulse_clear();
    check_val("clr_cnt2", cnt2, 0);
    check_val("clr_cnt8", cnt8, 0);
    pll_locked = 1'b1;
    repeat (14) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk); @(negedge clk);
    clear_loss = 1'b1;
    @(negedge clk);
    clear_loss = 1'b0;
    check_val("clrloss_cnt2", cnt2, 1);
    check_val("clrloss_cnt8", cnt8, 1);
    repeat (3) @(negedge clk);

    // Asynchronous reset during RELEASE
    pll_locked = 1'b1;
    wait_bit0_low("arst");
    #2 rst = 1'b1;
    #1;
    check_val("arst_rst_out", rst_out, 3'b111);
    check_val("arst_ready",   ready,   0);
    check_val("arst_cnt",     cnt8,    0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    measure_release("arst_restart");

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
